// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message-word window.
package sha256_pkg;

    localparam int N_BLK_WORDS  = 16;
    localparam int N_ROUNDS_DEF = 64;

    localparam int TAP_M2  = 14;
    localparam int TAP_M7  = 9;
    localparam int TAP_M15 = 1;
    localparam int TAP_M16 = 0;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } state_e;

endpackage

// File: rtl/sha256_w_regfile.sv
// 16-entry message window: indexed write while loading, shift-in while expanding.
// Entry 0 is the oldest word; all entries are exposed read-only.
module sha256_w_regfile
    import sha256_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [3:0]                            wr_idx,
    input  logic [WORD_W-1:0]                     wr_data,
    input  logic                                  shift_en,
    input  logic [WORD_W-1:0]                     shift_data,
    output logic [N_BLK_WORDS-1:0][WORD_W-1:0]    win
);

    logic [N_BLK_WORDS-1:0][WORD_W-1:0] win_q;
    logic [N_BLK_WORDS-1:0][WORD_W-1:0] win_d;

    // Shift drops the oldest word and appends the freshly expanded one at the top.
    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            win_d = {shift_data, win_q[N_BLK_WORDS-1:1]};
        end else if (wr_en) begin
            win_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win = win_q;

endmodule

// File: rtl/sha256_w_window.sv
// SHA-256 message-word window and sequencer: loads 16 words, streams W[0..N_ROUNDS-1].
// Optional macro SHA256_W_EARLY_OUT_EN forwards W[0..15] during the load beats.
module sha256_w_window
    import sha256_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int N_ROUNDS = N_ROUNDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [5:0]        out_t,
    output logic              done,
    output logic              sched_ena,
    output logic [WORD_W-1:0] sched_w_m2,
    output logic [WORD_W-1:0] sched_w_m7,
    output logic [WORD_W-1:0] sched_w_m15,
    output logic [WORD_W-1:0] sched_w_m16,
    input  logic [WORD_W-1:0] sched_w_t
);

    localparam logic [5:0] T_LAST = 6'(N_ROUNDS - 1);
    localparam logic [5:0] T_EXP  = 6'd16;
`ifdef SHA256_W_EARLY_OUT_EN
    localparam logic [5:0] T_START = 6'd16;
`else
    localparam logic [5:0] T_START = 6'd0;
`endif

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] t_q, t_d;
    logic       done_q, done_d;
    logic       wr_en;
    logic       shift_en;

    logic [N_BLK_WORDS-1:0][WORD_W-1:0] win;

    sha256_w_regfile #(
        .WORD_W(WORD_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (cnt_q),
        .wr_data    (in_word),
        .shift_en   (shift_en),
        .shift_data (sched_w_t),
        .win        (win)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        shift_en  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_word  = '0;
        out_t     = t_q;
        sched_ena = 1'b0;

        case (state_q)
            LOAD: begin
`ifdef SHA256_W_EARLY_OUT_EN
                in_ready  = out_ready;
                out_valid = in_valid;
                out_word  = in_word;
                out_t     = {2'b00, cnt_q};
`else
                in_ready  = 1'b1;
`endif
                if (in_valid && in_ready) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = EXPAND;
                        cnt_d   = 4'd0;
                        t_d     = T_START;
                    end
                end
            end

            EXPAND: begin
                out_valid = 1'b1;
                if (t_q < T_EXP) begin
                    out_word = win[t_q[3:0]];
                end else begin
                    out_word  = sched_w_t;
                    sched_ena = 1'b1;
                end
                // The window only advances on an accepted expanded word, so taps hold during stalls.
                if (out_ready) begin
                    t_d      = t_q + 6'd1;
                    shift_en = (t_q >= T_EXP);
                    if (t_q == T_LAST) begin
                        state_d = LOAD;
                        cnt_d   = 4'd0;
                        t_d     = 6'd0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= 4'd0;
            t_q     <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    assign done        = done_q;
    assign sched_w_m2  = win[TAP_M2];
    assign sched_w_m7  = win[TAP_M7];
    assign sched_w_m15 = win[TAP_M15];
    assign sched_w_m16 = win[TAP_M16];

endmodule

// File: tb/tb_sha256_w_window.sv
// Self-checking bench for sha256_w_window with a behavioural expander on the sched_* ports.
module tb_sha256_w_window;

   typedef logic [31:0] blk_t [16];
   typedef logic [31:0] w64_t [64];

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [5:0]  out_t;
   logic        done;
   logic        sched_ena;
   logic [31:0] sched_w_m2;
   logic [31:0] sched_w_m7;
   logic [31:0] sched_w_m15;
   logic [31:0] sched_w_m16;
   logic [31:0] sched_w_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] got_word [$];
   logic [5:0]  got_t [$];
   int          got_cyc [$];
   int          in_cyc [$];
   int          done_cyc_q [$];

   logic        prev_stall = 1'b0;
   logic        prev_done = 1'b0;
   logic [31:0] prev_word;
   logic [5:0]  prev_t;
   logic [127:0] prev_taps;

   blk_t blk_abc;
   blk_t blk_two;
   w64_t ref_abc;
   w64_t ref_two;

   sha256_w_window dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_word     (in_word),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_word    (out_word),
      .out_t       (out_t),
      .done        (done),
      .sched_ena   (sched_ena),
      .sched_w_m2  (sched_w_m2),
      .sched_w_m7  (sched_w_m7),
      .sched_w_m15 (sched_w_m15),
      .sched_w_m16 (sched_w_m16),
      .sched_w_t   (sched_w_t)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // External expander: combinational W[t] from the four window taps.
   assign sched_w_t = sig1(sched_w_m2) + sched_w_m7 + sig0(sched_w_m15) + sched_w_m16;

   // Reference message schedule computed straight from the block.
   function automatic void computeRef(input blk_t b, output w64_t w);
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = b[i];
         else w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
      end
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Passive monitor: logs handshakes, checks done width, sched_ena and stall stability.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) in_cyc.push_back(cyc);
         if (out_valid && out_ready) begin
            got_word.push_back(out_word);
            got_t.push_back(out_t);
            got_cyc.push_back(cyc);
            checkOutput("sched_ena", 32'(sched_ena), 32'(out_t >= 6'd16));
         end
         if (done) begin
            done_cyc_q.push_back(cyc);
            checkOutput("done_pulse_width", 32'(prev_done), 32'd0);
         end
         if (prev_stall && out_valid) begin
            checkOutput("stall_word", out_word, prev_word);
            checkOutput("stall_t", 32'(out_t), 32'(prev_t));
            checkOutput("stall_taps", 32'({sched_w_m2, sched_w_m7, sched_w_m15, sched_w_m16} == prev_taps), 32'd1);
         end
         prev_stall = out_valid && !out_ready;
         prev_word  = out_word;
         prev_t     = out_t;
         prev_taps  = {sched_w_m2, sched_w_m7, sched_w_m15, sched_w_m16};
      end else begin
         prev_stall = 1'b0;
      end
      prev_done = done;
   end

   task automatic clearLog();
      got_word.delete();
      got_t.delete();
      got_cyc.delete();
      in_cyc.delete();
      done_cyc_q.delete();
   endtask

   // Drives one 16-word block, optionally with random idle gaps between words.
   task automatic applyStimulus(input blk_t b, input bit gaps);
      bit ok;
      int n;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
               in_valid = 1'b0;
               @(negedge clk);
`ifndef SHA256_W_EARLY_OUT_EN
               checkOutput("in_ready_gap", 32'(in_ready), 32'd1);
`endif
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_word  = b[i];
         ok = 1'b0;
         for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
         end
         checkOutput("in_accept", 32'(ok), 32'd1);
      end
      in_valid = 1'b0;
   endtask

   // Waits for the given number of done pulses, optionally toggling out_ready every cycle.
   task automatic waitBlock(input int target, input bit toggle);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 600 && !ok; k++) begin
         @(posedge clk);
         #1;
         if (toggle) out_ready = ~out_ready;
         if (done_cyc_q.size() >= target) ok = 1'b1;
      end
      out_ready = 1'b1;
      checkOutput("done_seen", 32'(ok), 32'd1);
   endtask

   task automatic checkBlock(input string tag, input int base, input int didx, input w64_t w);
      bit have;
      have = (got_word.size() >= base + 64) && (done_cyc_q.size() > didx);
      checkOutput({tag, "_complete"}, 32'(have), 32'd1);
      if (have) begin
         for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("%s_w%0d", tag, i), got_word[base+i], w[i]);
            checkOutput($sformatf("%s_t%0d", tag, i), 32'(got_t[base+i]), 32'(i));
         end
         checkOutput({tag, "_done_cycle"}, 32'(done_cyc_q[didx]), 32'(got_cyc[base+63] + 1));
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      out_ready = 1'b1;

      for (int i = 0; i < 16; i++) begin
         blk_abc[i] = 32'h0;
         blk_two[i] = 32'h9E3779B9 * (i + 1) ^ 32'h0F0F1234;
      end
      blk_abc[0]  = 32'h61626380;
      blk_abc[15] = 32'h00000018;
      computeRef(blk_abc, ref_abc);
      computeRef(blk_two, ref_two);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_sched_ena", 32'(sched_ena), 32'd0);
      checkOutput("rst_out_t", 32'(out_t), 32'd0);

      $display("[TB] abc block, out_ready held high");
      clearLog();
      applyStimulus(blk_abc, 1'b0);
      waitBlock(1, 1'b0);
      checkBlock("abc", 0, 0, ref_abc);
      if (got_word.size() >= 64 && in_cyc.size() >= 16) begin
         checkOutput("abc_W16", got_word[16], 32'h61626380);
         checkOutput("abc_W17", got_word[17], 32'h000F0000);
         checkOutput("abc_W18", got_word[18], 32'h7DA86405);
         checkOutput("abc_W63", got_word[63], 32'h12B1EDEB);
`ifdef SHA256_W_EARLY_OUT_EN
         for (int i = 0; i < 16; i++)
            checkOutput($sformatf("early_beat%0d", i), 32'(got_cyc[i]), 32'(in_cyc[i]));
         checkOutput("early_W16_latency", 32'(got_cyc[16]), 32'(in_cyc[15] + 1));
`else
         checkOutput("W0_latency", 32'(got_cyc[0]), 32'(in_cyc[15] + 1));
`endif
      end else begin
         checkOutput("abc_log_size", 32'(got_word.size()), 32'd64);
      end

      $display("[TB] abc block, out_ready toggling");
      clearLog();
      applyStimulus(blk_abc, 1'b0);
      waitBlock(1, 1'b1);
      checkBlock("toggle", 0, 0, ref_abc);

      $display("[TB] abc block, random input gaps");
      clearLog();
      applyStimulus(blk_abc, 1'b1);
      waitBlock(1, 1'b0);
      checkBlock("gaps", 0, 0, ref_abc);

      $display("[TB] reset in the middle of expansion");
      clearLog();
      applyStimulus(blk_abc, 1'b0);
      begin
         bit ok;
         ok = 1'b0;
         for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (out_valid && out_t == 6'd30) ok = 1'b1;
         end
         checkOutput("reach_t30", 32'(ok), 32'd1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_out_t", 32'(out_t), 32'd0);
      checkOutput("midrst_sched_ena", 32'(sched_ena), 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("midrst_no_done", 32'(done_cyc_q.size()), 32'd0);
      clearLog();
      applyStimulus(blk_abc, 1'b0);
      waitBlock(1, 1'b0);
      checkBlock("after_rst", 0, 0, ref_abc);

      $display("[TB] two back-to-back blocks");
      clearLog();
      applyStimulus(blk_abc, 1'b0);
      applyStimulus(blk_two, 1'b0);
      waitBlock(2, 1'b0);
      checkBlock("b2b_first", 0, 0, ref_abc);
      checkBlock("b2b_second", 64, 1, ref_two);
      if (got_cyc.size() >= 64 && in_cyc.size() >= 17) begin
         checkOutput("b2b_reload_cycle", 32'(in_cyc[16]), 32'(got_cyc[63] + 1));
      end else begin
         checkOutput("b2b_in_log_size", 32'(in_cyc.size()), 32'd32);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
